// File: rtl/fc_argmax_if.sv
// Score bus between the FC controller and the argmax comparator.
// Carries the start/hold request, ten scores, the winning index and done.
interface fc_argmax_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  enable;
  logic [DATA_WIDTH-1:0] Arr0;
  logic [DATA_WIDTH-1:0] Arr1;
  logic [DATA_WIDTH-1:0] Arr2;
  logic [DATA_WIDTH-1:0] Arr3;
  logic [DATA_WIDTH-1:0] Arr4;
  logic [DATA_WIDTH-1:0] Arr5;
  logic [DATA_WIDTH-1:0] Arr6;
  logic [DATA_WIDTH-1:0] Arr7;
  logic [DATA_WIDTH-1:0] Arr8;
  logic [DATA_WIDTH-1:0] Arr9;
  logic [3:0]            result;
  logic                  done;

  modport master (
    output enable,
    output Arr0, Arr1, Arr2, Arr3, Arr4,
    output Arr5, Arr6, Arr7, Arr8, Arr9,
    input  result,
    input  done
  );

  modport slave (
    input  enable,
    input  Arr0, Arr1, Arr2, Arr3, Arr4,
    input  Arr5, Arr6, Arr7, Arr8, Arr9,
    output result,
    output done
  );
endinterface

// File: rtl/fc_argmax_comparator.sv
// Sequential argmax over ten signed FC scores, one compare per clock.
// Lowest index wins ties; done holds until enable is withdrawn.
module fc_argmax_comparator #(
  parameter int DATA_WIDTH = 16
) (
  input  logic      clk,
  input  logic      reset,
  fc_argmax_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef logic signed [DATA_WIDTH-1:0] score_t;

  logic [1:0] state_q, state_d;
  score_t     cap_q [10];
  score_t     cap_d [10];
  score_t     arr_in [10];
  score_t     best_val_q, best_val_d;
  logic [3:0] best_idx_q, best_idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] result_q, result_d;
  logic       done_q, done_d;
  score_t     cur;
  logic       gt;
  logic [3:0] win_idx;

  always_comb begin
    arr_in[0] = bus.Arr0;
    arr_in[1] = bus.Arr1;
    arr_in[2] = bus.Arr2;
    arr_in[3] = bus.Arr3;
    arr_in[4] = bus.Arr4;
    arr_in[5] = bus.Arr5;
    arr_in[6] = bus.Arr6;
    arr_in[7] = bus.Arr7;
    arr_in[8] = bus.Arr8;
    arr_in[9] = bus.Arr9;
  end

  // Counter is held in 1..9 while scanning, so the mux never sees 10..15.
  always_comb begin
    cur = cap_q[0];
    for (int k = 1; k < 10; k++) begin
      if (cnt_q == 4'(k)) cur = cap_q[k];
    end
  end

  assign gt      = cur > best_val_q;
  assign win_idx = gt ? cnt_q : best_idx_q;

  always_comb begin
    state_d    = state_q;
    cap_d      = cap_q;
    best_val_d = best_val_q;
    best_idx_d = best_idx_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    done_d     = done_q;
    unique case (state_q)
      IDLE: begin
        done_d = 1'b0;
        if (bus.enable) begin
          cap_d      = arr_in;
          best_val_d = arr_in[0];
          best_idx_d = 4'd0;
          cnt_d      = 4'd1;
          state_d    = SCAN;
        end
      end
      SCAN: begin
        if (!bus.enable) begin
          state_d = IDLE;
          done_d  = 1'b0;
        end else begin
          if (gt) begin
            best_val_d = cur;
            best_idx_d = cnt_q;
          end
          if (cnt_q == 4'd9) begin
            result_d = win_idx;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      DONE: begin
        done_d = 1'b1;
        if (!bus.enable) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      best_val_q <= '0;
      best_idx_q <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      for (int k = 0; k < 10; k++) cap_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      cap_q      <= cap_d;
      best_val_q <= best_val_d;
      best_idx_q <= best_idx_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      done_q     <= done_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_fc_argmax_comparator.sv
// Directed bench for fc_argmax_comparator.
// Scenario tasks check latency, signed compare, ties, reset and handshake.
module tb_fc_argmax_comparator;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] vec [10];
  int          total;
  int          bad;

  fc_argmax_if #(.DATA_WIDTH(16)) bus ();

  assign bus.enable = en;
  assign bus.Arr0   = vec[0];
  assign bus.Arr1   = vec[1];
  assign bus.Arr2   = vec[2];
  assign bus.Arr3   = vec[3];
  assign bus.Arr4   = vec[4];
  assign bus.Arr5   = vec[5];
  assign bus.Arr6   = vec[6];
  assign bus.Arr7   = vec[7];
  assign bus.Arr8   = vec[8];
  assign bus.Arr9   = vec[9];

  fc_argmax_comparator #(.DATA_WIDTH(16)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic run_scan(output int cyc, output logic [3:0] res);
    @(negedge clk);
    en  = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (bus.done !== 1'b1 && cyc < 20);
    res = bus.result;
  endtask

  task automatic drop_enable(input logic [3:0] keep, input string nm);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (bus.done !== 1'b0 || bus.result !== keep) begin
      bad++;
      $display("FAIL %s: done=%b result=%0d want done=0 result=%0d",
               nm, bus.done, bus.result, keep);
    end
  endtask

  task automatic check_run(input logic [3:0] want, input string nm);
    int         cyc;
    logic [3:0] res;
    run_scan(cyc, res);
    total++;
    if (cyc !== 10) begin
      bad++;
      $display("FAIL %s latency: got %0d want 10", nm, cyc);
    end
    total++;
    if (res !== want) begin
      bad++;
      $display("FAIL %s result: got %0d want %0d", nm, res, want);
    end
  endtask

  task automatic test_reset;
    en    = 1'b0;
    vec   = '{16'h0800, 16'h0000, 16'h0001, 16'h0002, 16'h0004,
              16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080};
    rst_n = 1'b0;
    #50;
    total++;
    if (bus.done !== 1'b0 || bus.result !== 4'd0) begin
      bad++;
      $display("FAIL reset: done=%b result=%0d want 0/0",
               bus.done, bus.result);
    end
    #50;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_max;
    check_run(4'd0, "first_max");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      total++;
      if (bus.done !== 1'b1 || bus.result !== 4'd0) begin
        bad++;
        $display("FAIL hold: cycle %0d done=%b result=%0d want 1/0",
                 i, bus.done, bus.result);
      end
    end
    drop_enable(4'd0, "first_drop");
  endtask

  task automatic test_last_max;
    vec = '{16'h0000, 16'h0020, 16'h0040, 16'h0060, 16'h0080,
            16'h00A0, 16'h00C0, 16'h00E0, 16'h0100, 16'h7FFF};
    check_run(4'd9, "last_max");
    drop_enable(4'd9, "last_drop");
  endtask

  task automatic test_signed;
    vec    = '{default: 16'h8000};
    vec[3] = 16'hFFFF;
    check_run(4'd3, "signed_neg1");
    drop_enable(4'd3, "signed_drop1");
    vec    = '{16'hFFFF, 16'h8000, 16'hFF00, 16'hFFFE, 16'h8001,
              16'h0001, 16'hC000, 16'hFFFF, 16'h8000, 16'hF000};
    check_run(4'd5, "signed_pos");
    drop_enable(4'd5, "signed_drop2");
  endtask

  task automatic test_tie;
    vec    = '{default: 16'h0000};
    vec[2] = 16'h0100;
    vec[5] = 16'h0100;
    check_run(4'd2, "tie");
    drop_enable(4'd2, "tie_drop");
  endtask

  task automatic test_reset_mid_scan;
    int cyc;
    vec    = '{default: 16'h0010};
    vec[6] = 16'h1234;
    @(negedge clk);
    en = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (bus.done !== 1'b0 || bus.result !== 4'd0) begin
      bad++;
      $display("FAIL mid_reset: done=%b result=%0d want 0/0",
               bus.done, bus.result);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (bus.done !== 1'b1 && cyc < 20);
    total++;
    if (cyc !== 10) begin
      bad++;
      $display("FAIL post_reset latency: got %0d want 10", cyc);
    end
    total++;
    if (bus.result !== 4'd6) begin
      bad++;
      $display("FAIL post_reset result: got %0d want 6", bus.result);
    end
  endtask

  task automatic test_handshake;
    int seen;
    drop_enable(4'd6, "hs_drop");
    vec[7] = 16'h7FFF;
    check_run(4'd7, "hs_rerun");
    drop_enable(4'd7, "hs_drop2");
    vec    = '{default: 16'h0000};
    vec[4] = 16'h4000;
    @(negedge clk);
    en = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    en   = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done !== 1'b0) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL abort done: high on %0d cycles want 0", seen);
    end
    total++;
    if (bus.result !== 4'd7) begin
      bad++;
      $display("FAIL abort result: got %0d want 7", bus.result);
    end
  endtask

  task automatic test_back_to_back;
    vec    = '{default: 16'h0001};
    vec[8] = 16'h0002;
    check_run(4'd8, "b2b_a");
    drop_enable(4'd8, "b2b_drop");
    vec    = '{default: 16'hFFF0};
    vec[1] = 16'h0000;
    check_run(4'd1, "b2b_b");
    drop_enable(4'd1, "b2b_drop2");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_first_max();
    test_last_max();
    test_signed();
    test_tie();
    test_reset_mid_scan();
    test_handshake();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
